// File: rtl/if_stage_if.sv
// Groups the fetch stage's decode-side and instruction-memory signals.
// master = the fetch stage, slave = decode/memory environment.
interface if_stage_if;
    logic        stall_ID;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_ID;
    logic [31:0] pc_plus4_ID;
    logic        instr_valid_ID;

    modport master (
        input  stall_ID, redirect_valid, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output instruction, pc_ID, pc_plus4_ID, instr_valid_ID
    );

    modport slave (
        output stall_ID, redirect_valid, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  instruction, pc_ID, pc_plus4_ID, instr_valid_ID
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, one outstanding imem request, feeds the IF/ID register.
// Latency: gnt in N, rvalid in N+1, valid in IF/ID at N+2; 1 instr/cycle at steady state.
// Backpressure: stall_ID holds IF/ID, a 1-entry skid buffer catches the in-flight word.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] PC_MASK = ~32'd3;

    state_t      state;
    logic [31:0] pc_fetch;
    logic [31:0] inflight_pc;
    logic        skid_full;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        req;
    logic        fire;
    logic        deliver;
    logic [31:0] target_pc;

    assign target_pc = bus.redirect_pc & PC_MASK;

    always_comb begin
        req = 1'b0;
        case (state)
            S_FETCH: req = !skid_full && !bus.redirect_valid;
            S_WAIT:  req = bus.imem_rvalid && !bus.stall_ID && !bus.redirect_valid;
            default: req = 1'b0;
        endcase
    end

    // A held reset must silence the port even though the FSM already sits in FETCH.
    assign bus.imem_req  = req && reset;
    assign bus.imem_addr = pc_fetch;

    assign fire    = req && bus.imem_gnt;
    assign deliver = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc_fetch    <= RESET_PC & PC_MASK;
            inflight_pc <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.redirect_valid) begin
                        pc_fetch <= target_pc;
                    end else if (fire) begin
                        state       <= S_WAIT;
                        inflight_pc <= pc_fetch;
                        pc_fetch    <= pc_fetch + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.redirect_valid) begin
                            pc_fetch <= target_pc;
                            state    <= S_FETCH;
                        end else if (fire) begin
                            inflight_pc <= pc_fetch;
                            pc_fetch    <= pc_fetch + 32'd4;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (bus.redirect_valid) begin
                        // Response still owed for a pre-redirect address: swallow it in DRAIN.
                        pc_fetch <= target_pc;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.redirect_valid) begin
                        pc_fetch <= target_pc;
                    end
                    if (bus.imem_rvalid) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full          <= 1'b0;
            skid_instr         <= NOP_INSTR;
            skid_pc            <= 32'd0;
            bus.instruction    <= NOP_INSTR;
            bus.pc_ID          <= 32'd0;
            bus.pc_plus4_ID    <= 32'd4;
            bus.instr_valid_ID <= 1'b0;
        end else if (bus.redirect_valid) begin
            skid_full          <= 1'b0;
            bus.instruction    <= NOP_INSTR;
            bus.instr_valid_ID <= 1'b0;
        end else if (bus.stall_ID) begin
            if (deliver) begin
                skid_full  <= 1'b1;
                skid_instr <= bus.imem_rdata;
                skid_pc    <= inflight_pc;
            end
        end else if (skid_full) begin
            skid_full          <= 1'b0;
            bus.instruction    <= skid_instr;
            bus.pc_ID          <= skid_pc;
            bus.pc_plus4_ID    <= skid_pc + 32'd4;
            bus.instr_valid_ID <= 1'b1;
        end else if (deliver) begin
            bus.instruction    <= bus.imem_rdata;
            bus.pc_ID          <= inflight_pc;
            bus.pc_plus4_ID    <= inflight_pc + 32'd4;
            bus.instr_valid_ID <= 1'b1;
        end else begin
            bus.instruction    <= NOP_INSTR;
            bus.instr_valid_ID <= 1'b0;
        end
    end

endmodule
